// File: rtl/conv_sink_pkg.sv
// conv_sink_pkg: state encoding, address-width helper and checksum width shared by conv_stream_sink.
package conv_sink_pkg;
    typedef enum logic [1:0] {IDLE = 2'b00, CAPTURE = 2'b01, DONE = 2'b10} state_e;
    localparam int CSUM_W = 32;
    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction
endpackage

// File: rtl/conv_sink_ram.sv
// conv_sink_ram: simple dual-port RAM, read-first, registered read data with rd_valid companion.
module conv_sink_ram #(
    parameter int W      = 16,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [W-1:0]      wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [W-1:0]      rdata,
    output logic              rvalid
);
    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rdata_q, rdata_d;
    logic         rvalid_q;

    always_comb rdata_d = re ? mem[raddr] : rdata_q;

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    // Only the output register is reset; array contents survive reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= re;
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
endmodule

// File: rtl/conv_stream_sink.sv
// conv_stream_sink: captures one run of the conv_top output stream per running pulse into a buffer.
// Define CONV_SINK_CHECKSUM_EN to add a 32-bit modular sum of accepted samples (checksum_o).
module conv_stream_sink
    import conv_sink_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int CH       = 1,
    parameter int DEPTH    = 1024,
    parameter int EXPECTED = 0,
    parameter int CNT_W    = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CH*DATA_W-1:0]       in_data,
    input  logic                       in_valid,
    input  logic                       in_running,
    input  logic                       rd_en,
    input  logic [addr_w(DEPTH)-1:0]   rd_addr,
    output logic [CH*DATA_W-1:0]       rd_data,
    output logic                       rd_valid,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [CNT_W-1:0]           count_o,
    output logic                       overflow_o,
    output logic                       mismatch_o
`ifdef CONV_SINK_CHECKSUM_EN
    ,
    output logic [CSUM_W-1:0]          checksum_o
`endif
);
    localparam int ADDR_W = addr_w(DEPTH);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d, count_base;
    logic [ADDR_W:0]  wptr_q, wptr_d, wptr_base;
    logic             ovf_q, ovf_d, mis_q, mis_d, done_q, done_d;
    logic             start, accept, room, we, run_end;

    // A starting run sees cleared bases so its first beat lands in entry 0.
    always_comb begin
        start      = in_running && state_q != CAPTURE;
        run_end    = state_q == CAPTURE && !in_running;
        accept     = in_running && in_valid;
        count_base = start ? '0 : count_q;
        wptr_base  = start ? '0 : wptr_q;
        room       = wptr_base < (ADDR_W+1)'(DEPTH);
        we         = accept && room && !rst;
        state_d    = in_running ? CAPTURE : run_end ? DONE : state_q;
        count_d    = (accept && count_base != '1) ? count_base + CNT_W'(1) : count_base;
        wptr_d     = (accept && room) ? wptr_base + (ADDR_W+1)'(1) : wptr_base;
        ovf_d      = (start ? 1'b0 : ovf_q) | (accept && !room);
        done_d     = start ? 1'b0 : run_end ? 1'b1 : done_q;
        mis_d      = start ? 1'b0 : run_end ? (EXPECTED != 0 && count_q != CNT_W'(EXPECTED)) : mis_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            wptr_q  <= '0;
            ovf_q   <= 1'b0;
            mis_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            wptr_q  <= wptr_d;
            ovf_q   <= ovf_d;
            mis_q   <= mis_d;
            done_q  <= done_d;
        end
    end

    conv_sink_ram #(.W(CH*DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .waddr  (wptr_base[ADDR_W-1:0]),
        .wdata  (in_data),
        .re     (rd_en),
        .raddr  (rd_addr),
        .rdata  (rd_data),
        .rvalid (rd_valid)
    );

    assign busy_o     = state_q == CAPTURE;
    assign done_o     = done_q;
    assign count_o    = count_q;
    assign overflow_o = ovf_q;
    assign mismatch_o = mis_q;

`ifdef CONV_SINK_CHECKSUM_EN
    logic [CSUM_W-1:0] csum_q, csum_d;

    always_comb begin
        csum_d = start ? '0 : csum_q;
        for (int c = 0; c < CH; c++)
            csum_d = accept ? csum_d + CSUM_W'(in_data[c*DATA_W +: DATA_W]) : csum_d;
    end

    always_ff @(posedge clk) begin
        if (rst) csum_q <= '0;
        else     csum_q <= csum_d;
    end

    assign checksum_o = csum_q;
`endif
endmodule

// File: tb/tb_conv_stream_sink.sv
// tb_conv_stream_sink: directed runs checked every cycle against a run-level model plus literal pins.
module tb_conv_stream_sink;
    localparam int DATA_W = 16, CH = 1, DEPTH = 16, EXPECTED = 10, CNT_W = 32;

    logic        clk = 0, rst = 1;
    logic [15:0] in_data = '0;
    logic        in_valid = 0, in_running = 0, rd_en = 0;
    logic [3:0]  rd_addr = '0;
    logic [15:0] rd_data;
    logic        rd_valid, busy_o, done_o, overflow_o, mismatch_o;
    logic [31:0] count_o;
`ifdef CONV_SINK_CHECKSUM_EN
    logic [31:0] checksum_o;
`endif

    always #5 clk = ~clk;

    conv_stream_sink #(.DATA_W(DATA_W), .CH(CH), .DEPTH(DEPTH), .EXPECTED(EXPECTED), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_running (in_running),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .count_o    (count_o),
        .overflow_o (overflow_o),
        .mismatch_o (mismatch_o)
`ifdef CONV_SINK_CHECKSUM_EN
        ,
        .checksum_o (checksum_o)
`endif
    );

    int vectors = 0, miscompares = 0;
    bit chk_en = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Run-level model: a run is the span of cycles with in_running high.
    bit          m_run, m_ovf, m_done, m_mis, m_rdv, m_rd_known;
    int          m_count, m_n;
    logic [15:0] m_mem [DEPTH];
    bit          m_known [DEPTH];
    logic [15:0] m_rd;
    logic [31:0] m_csum;

    always @(posedge clk) begin
        if (rst) begin
            m_run = 0; m_count = 0; m_n = 0; m_ovf = 0; m_done = 0; m_mis = 0;
            m_rd = '0; m_rdv = 0; m_rd_known = 1; m_csum = '0;
        end else begin
            if (rd_en) begin
                m_rd = m_mem[rd_addr];
                m_rd_known = m_known[rd_addr];
            end
            m_rdv = rd_en;
            if (in_running && !m_run) begin
                m_count = 0; m_n = 0; m_ovf = 0; m_done = 0; m_mis = 0; m_csum = '0;
            end
            if (in_running && in_valid) begin
                m_count++;
                m_csum += 32'(in_data);
                if (m_n < DEPTH) begin
                    m_mem[m_n] = in_data;
                    m_known[m_n] = 1;
                    m_n++;
                end else m_ovf = 1;
            end
            if (!in_running && m_run) begin
                m_done = 1;
                m_mis = m_count != EXPECTED;
            end
            m_run = in_running;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", busy_o, m_run);
            check("done", done_o, m_done);
            check("count", count_o, m_count);
            check("overflow", overflow_o, m_ovf);
            check("mismatch", mismatch_o, m_mis);
            check("rd_valid", rd_valid, m_rdv);
            if (m_rdv && m_rd_known) check("rd_data", rd_data, m_rd);
`ifdef CONV_SINK_CHECKSUM_EN
            check("checksum", checksum_o, m_csum);
`endif
        end
    end

    task automatic step(input bit r, input bit v, input logic [15:0] d,
                        input bit re = 0, input logic [3:0] ra = '0);
        in_running = r; in_valid = v; in_data = d; rd_en = re; rd_addr = ra;
        @(negedge clk);
        rd_en = 0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [15:0] exp);
        step(0, 0, 0, 1, a);
        check("rd_valid_lit", rd_valid, 1);
        check("rd_data_lit", rd_data, exp);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_count", count_o, 0);
        check("rst_ovf", overflow_o, 0);
        check("rst_rdv", rd_valid, 0);
        rst = 0;
        chk_en = 1;

        // Run of 10 beats
        for (int i = 1; i <= 10; i++) begin
            step(1, 1, 16'(i));
            if (i == 1) check("r1_busy", busy_o, 1);
        end
        check("r1_done_early", done_o, 0);
        step(0, 0, 0);
        check("r1_done", done_o, 1);
        check("r1_count", count_o, 10);
        check("r1_ovf", overflow_o, 0);
        check("r1_mis", mismatch_o, 0);
`ifdef CONV_SINK_CHECKSUM_EN
        check("r1_csum", checksum_o, 55);
`endif
        for (int a = 0; a < 10; a++) rd(4'(a), 16'(a + 1));
        step(0, 0, 0);
        check("r1_rdv_drop", rd_valid, 0);

        // Run of 20 beats overflows the 16-entry buffer
        for (int i = 1; i <= 20; i++) step(1, 1, 16'(i));
        step(0, 0, 0);
        check("r2_count", count_o, 20);
        check("r2_ovf", overflow_o, 1);
        check("r2_mis", mismatch_o, 1);
        rd(4'd15, 16'd16);
        rd(4'd0, 16'd1);

        // Valid toggling: only even data accepted
        for (int i = 1; i <= 10; i++) step(1, (i % 2) == 0, 16'(i));
        step(0, 0, 0);
        check("r3_count", count_o, 5);
        check("r3_mis", mismatch_o, 1);
        check("r3_ovf", overflow_o, 0);
        rd(4'd0, 16'd2);
        rd(4'd4, 16'd10);

        // Back-to-back runs with one idle cycle
        for (int i = 1; i <= 3; i++) step(1, 1, 16'(16'h10 + i));
        step(0, 0, 0);
        check("r4a_done", done_o, 1);
        check("r4a_count", count_o, 3);
        step(1, 1, 16'h21);
        check("r4b_done_clr", done_o, 0);
        check("r4b_busy", busy_o, 1);
        for (int i = 2; i <= 4; i++) step(1, 1, 16'(16'h20 + i));
        step(0, 0, 0);
        check("r4b_count", count_o, 4);
        check("r4b_ovf", overflow_o, 0);
        rd(4'd3, 16'h24);

        // Reset mid-run with running held high
        for (int i = 1; i <= 5; i++) step(1, 1, 16'(16'h40 + i));
        rst = 1;
        step(1, 1, 16'h99);
        rst = 0;
        check("r5_rst_busy", busy_o, 0);
        check("r5_rst_count", count_o, 0);
        step(1, 1, 16'h31);
        check("r5_busy", busy_o, 1);
        check("r5_count", count_o, 1);
        check("r5_ovf", overflow_o, 0);
        check("r5_mis", mismatch_o, 0);
        for (int i = 2; i <= 4; i++) step(1, 1, 16'(16'h30 + i));
        step(0, 0, 0);
        check("r5_end_count", count_o, 4);

        // Read and write address 3 in the same cycle: read-first
        step(1, 1, 16'hA0);
        step(1, 1, 16'hA1);
        step(1, 1, 16'hA2);
        step(1, 1, 16'h55, 1, 4'd3);
        check("rw_old", rd_data, 16'h34);
        step(0, 0, 0);
        rd(4'd3, 16'h55);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
